// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and loads the IF/ID pipeline register. Applies stall,
// flush and branch/jump/jr redirects from decode and the hazard unit.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic [1:0]  pc_src_d,
  input  logic [31:0] branch_tgt_d,
  input  logic [31:0] jump_tgt_d,
  input  logic [31:0] jr_tgt_d,
  output logic [31:0] imem_adr,
  input  logic [31:0] imem_dout,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic        valid_d
);

  typedef enum logic [1:0] {
    SRC_SEQ = 2'b00,
    SRC_BR  = 2'b01,
    SRC_J   = 2'b10,
    SRC_JR  = 2'b11
  } pc_src_e;

  // Word count expressed in PC[31:2] width for the range compare.
  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  logic [31:0] prog_cnt_q, prog_cnt_d;
  logic [31:0] pc_plus4;
  logic        in_range;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_valid_q, ifid_valid_d;

  assign imem_adr = prog_cnt_q;
  assign pc_plus4 = prog_cnt_q + 32'd4;  // wraps modulo 2^32
  assign in_range = (prog_cnt_q[31:2] < DEPTH_W);

  // Next-PC selection: stall holds, otherwise sequential or word-aligned redirect.
  always_comb begin
    // NOTE: default first so every path assigns prog_cnt_d and no latch is inferred.
    prog_cnt_d = prog_cnt_q;
    if (!stall_f) begin
      case (pc_src_e'(pc_src_d))
        SRC_SEQ: prog_cnt_d = pc_plus4;
        SRC_BR:  prog_cnt_d = {branch_tgt_d[31:2], 2'b00};
        SRC_J:   prog_cnt_d = {jump_tgt_d[31:2], 2'b00};
        SRC_JR:  prog_cnt_d = {jr_tgt_d[31:2], 2'b00};
        default: prog_cnt_d = pc_plus4;
      endcase
    end
  end

  // IF/ID next state: flush beats stall, stall holds, otherwise capture the fetch.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_valid_d = ifid_valid_q;
    if (flush_d) begin
      ifid_instr_d = NOP_WORD;
      ifid_pc_d    = 32'h0;
      ifid_pcp4_d  = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (!stall_d) begin
      // Out-of-range fetches become a bubble but keep their PC metadata.
      ifid_instr_d = in_range ? imem_dout : NOP_WORD;
      ifid_pc_d    = prog_cnt_q;
      ifid_pcp4_d  = pc_plus4;
      ifid_valid_d = in_range;
    end
  end

  // PC and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_cnt_q   <= RESET_PC;
      ifid_instr_q <= NOP_WORD;
      ifid_pc_q    <= 32'h0;
      ifid_pcp4_q  <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values together.
      prog_cnt_q   <= prog_cnt_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pcplus4_d = ifid_pcp4_q;
  assign valid_d   = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count real loads and bubble loads into IF/ID; a stall (without flush) counts nothing.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_d || (!stall_d && !in_range)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (!stall_d) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process pushes the expected
// post-edge state, a monitor pops and compares it on the falling edge (or on
// an explicit sample event for the asynchronous-reset case).
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_f, stall_d, flush_d;
  logic [1:0]  pc_src_d;
  logic [31:0] branch_tgt_d, jump_tgt_d, jr_tgt_d;
  logic [31:0] imem_adr, imem_dout;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .pc_src_d     (pc_src_d),
    .branch_tgt_d (branch_tgt_d),
    .jump_tgt_d   (jump_tgt_d),
    .jr_tgt_d     (jr_tgt_d),
    .imem_adr     (imem_adr),
    .imem_dout    (imem_dout),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pcplus4_d    (pcplus4_d),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt),
`endif
    .valid_d      (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: 64 words; anything beyond returns all-ones so NOP injection is visible.
  logic [31:0] rom [64];
  assign imem_dout = (imem_adr[31:8] == 24'h0) ? rom[imem_adr[7:2]] : 32'hFFFF_FFFF;

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        valid;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per sample point and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, "/imem_adr"},  imem_adr,  e.adr);
        check({e.name, "/instr_d"},   instr_d,   e.instr);
        check({e.name, "/pc_d"},      pc_d,      e.pc);
        check({e.name, "/pcplus4_d"}, pcplus4_d, e.pcp4);
        check({e.name, "/valid_d"},   {31'h0, valid_d}, {31'h0, e.valid});
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] adr, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] pcp4, input logic valid);
    exp_t e;
    e.name = nm; e.adr = adr; e.instr = instr; e.pc = pc; e.pcp4 = pcp4; e.valid = valid;
    q.push_back(e);
  endtask

  // Drive one cycle of controls, take the edge, then queue the expected result.
  task automatic step(input string nm, input logic sf, input logic sd, input logic fl,
                      input logic [1:0] src, input logic [31:0] tgt,
                      input logic [31:0] adr, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] pcp4, input logic valid);
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src_d = src;
    branch_tgt_d = 32'h0000_0500;
    jump_tgt_d   = 32'h0000_0600;
    jr_tgt_d     = 32'h0000_0700;
    case (src)
      2'b01:   branch_tgt_d = tgt;
      2'b10:   jump_tgt_d   = tgt;
      2'b11:   jr_tgt_d     = tgt;
      default: ;
    endcase
    @(posedge clk);
    #1;
    push(nm, adr, instr, pc, pcp4, valid);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h8C01_0000;
    rom[1] = 32'h8C02_0004;
    rom[2] = 32'h0022_1820;
    rom[3] = 32'hAC03_0008;

    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_d = 2'b00;
    branch_tgt_d = 32'h0; jump_tgt_d = 32'h0; jr_tgt_d = 32'h0;
    #1;
    push("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    ->sample_ev;
    #1 rst = 1'b0;

    //   name        sf    sd    fl    src    tgt            adr            instr          pc             pcp4           valid
    step("seq0",     1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h4,         32'h8C01_0000, 32'h0,         32'h4,         1'b1);
    step("seq1",     1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h8,         32'h8C02_0004, 32'h4,         32'h8,         1'b1);
    // Stall both with a pending jump: PC must hold (stall beats redirect).
    step("stall0",   1'b1, 1'b1, 1'b0, 2'b10, 32'h40,        32'h8,         32'h8C02_0004, 32'h4,         32'h8,         1'b1);
    step("stall1",   1'b1, 1'b1, 1'b0, 2'b10, 32'h40,        32'h8,         32'h8C02_0004, 32'h4,         32'h8,         1'b1);
    step("resume8",  1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'hC,         32'h0022_1820, 32'h8,         32'hC,         1'b1);
    step("seqC",     1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h10,        32'hAC03_0008, 32'hC,         32'h10,        1'b1);
    // Taken branch to unaligned 0x23 with flush.
    step("br_flush", 1'b0, 1'b0, 1'b1, 2'b01, 32'h23,        32'h20,        32'h0,         32'h0,         32'h0,         1'b0);
    step("at20",     1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h24,        32'hA000_0008, 32'h20,        32'h24,        1'b1);
    // jr without flush: delay-slot word at 0x24 is captured.
    step("jr100",    1'b0, 1'b0, 1'b0, 2'b11, 32'h100,       32'h100,       32'hA000_0009, 32'h24,        32'h28,        1'b1);
    step("oor100",   1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h104,       32'h0,         32'h100,       32'h104,       1'b0);
    // Flush and stall_d together: flush wins.
    step("fl_stall", 1'b0, 1'b1, 1'b1, 2'b00, 32'h0,         32'h108,       32'h0,         32'h0,         32'h0,         1'b0);
    step("jmp6",     1'b0, 1'b0, 1'b0, 2'b10, 32'h6,         32'h4,         32'h0,         32'h108,       32'h10C,       1'b0);
    step("jr_top",   1'b0, 1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h8C02_0004, 32'h4,         32'h8,         1'b1);
    step("wrap",     1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         1'b0);
    step("w0",       1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h4,         32'h8C01_0000, 32'h0,         32'h4,         1'b1);
    step("w4",       1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h8,         32'h8C02_0004, 32'h4,         32'h8,         1'b1);
    step("w8",       1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'hC,         32'h0022_1820, 32'h8,         32'hC,         1'b1);
    step("wC",       1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h10,        32'hAC03_0008, 32'hC,         32'h10,        1'b1);
    step("w10",      1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h14,        32'hA000_0004, 32'h10,        32'h14,        1'b1);

`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt",  fetch_cnt,  32'd12);
    check("bubble_cnt", bubble_cnt, 32'd5);
`endif

    // Asynchronous reset pulse between edges while PC = 0x14.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    push("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    ->sample_ev;
    #1 rst = 1'b0;

    step("post_rst", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h4,         32'h8C01_0000, 32'h0,         32'h4,         1'b1);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
